subc_frame_ctrl: RTL and testbench
==================================

Name: subc_frame_ctrl

Overview:
- Frame sequencer that drives the subcarrier scrambler input.
- Walks every FFT bin of each OFDM symbol, classifies each bin as null, data, pilot or preamble, and pulls QAM data samples through a valid/ready handshake for data bins only.
- Emits a per-bin stream with sop/val/eop, subcarrier type index, and the frame's modulation and SS indices.
- Sits between the QAM mapper FIFO and the scrambler/IFFT chain.

Parameters:
- fft_depth, 12, I/Q sample width.
- NFFT_LOG, 10, log2 of bins per symbol (N = 1024).
- GUARD, 112, guard half-width; bins N/2-GUARD .. N/2+GUARD-1 are null.
- PILOT_STEP, 8, pilot spacing; power of 2.
- N_PRE, 1, preamble symbols per frame.
- PILOT_AMP, 12'd1024, pilot I value (Q = 0).
- PRE_AMP, 12'd1448, preamble I value on even bins (Q = 0).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- istart  in  1  frame start pulse
- cfg_M  in  3  modulation index for frame
- cfg_SS  in  4  SS index for frame
- cfg_nsym  in  8  data symbols per frame
- idata_i  in  fft_depth  QAM I
- idata_q  in  fft_depth  QAM Q
- idata_val  in  1  data valid
- odata_rdy  out  1  data ready
- osubc_i  out  fft_depth  bin I
- osubc_q  out  fft_depth  bin Q
- oindex_subc  out  2  0 null, 1 data, 2 pilot, 3 preamble
- index_M_out  out  3  latched cfg_M
- index_SS_out  out  4  latched cfg_SS
- osop  out  1  first bin of symbol
- oval  out  1  bin valid
- oeop  out  1  last bin of symbol
- obusy  out  1  frame in progress
- odone  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, rst = 1): FSM goes to IDLE, counters clear, and every registered output is 0, including odata_rdy.
- FSM states: IDLE, PRE, DATA, DONE.
  - IDLE -> PRE on istart = 1 with cfg_nsym != 0. cfg_M, cfg_SS and cfg_nsym are latched on that edge.
  - istart with cfg_nsym = 0 is ignored. istart outside IDLE is ignored.
  - PRE -> DATA after N_PRE symbols. If N_PRE = 0, go straight to DATA.
  - DATA -> DONE after the last bin of symbol cfg_nsym.
  - DONE -> IDLE after one cycle; odone = 1 during that cycle.
- obusy = 1 in PRE, DATA and DONE.
- Bin counter k runs 0..N-1 and wraps to 0 at each symbol; the symbol counter increments on wrap.
- Bin classification for bin k:
  - null: k == 0, or N/2-GUARD <= k < N/2+GUARD.
  - pilot: not null and k % PILOT_STEP == 0.
  - data: all other bins.
- Output per bin in PRE:
  - non-null bins: index 3, I = PRE_AMP on even k, 0 on odd k.
  - null bins: index 0, I = Q = 0.
- Output per bin in DATA:
  - null: index 0, zero.
  - pilot: index 2, I = PILOT_AMP, Q = 0.
  - data: index 1, I/Q = accepted sample.
- odata_rdy = 1 only when state == DATA and the current k is a data bin. It is a combinational decode of registered state/k.
- A transfer occurs when idata_val & odata_rdy. The bin is emitted next cycle and k advances.
- Data bin with idata_val = 0: stall. k holds and oval = 0 next cycle. Non-data bins never stall.
- All stream outputs are registered; latency from bin decision to oval is 1 cycle.
- osop = oval & (k == 0). oeop = oval & (k == N-1).
- index_M_out and index_SS_out hold their latched values until the next accepted istart.
- Per-symbol counts (defaults): 225 null, 99 pilot, 700 data; 799 non-null bins in a preamble symbol.
- osubc outputs are 0 whenever oval = 0.

Test Plan:
- Reset, then istart with cfg_nsym = 2 and idata_val held 1 -> 3 × 1024 oval cycles back-to-back; 3 osop and 3 oeop pulses; exactly 1400 data transfers; odone one cycle after the last oeop; obusy falls the following cycle.
- Preamble check -> k = 0 gives index 0; k = 2 gives index 3 with I = 1448; k = 3 gives index 3 with I = 0; k = 400..623 give index 0.
- DATA symbol with idata_val toggling 1/0 -> oval gaps only at data bins; k = 8 emits pilot I = 1024 without waiting; output data order matches input order.
- istart with cfg_nsym = 0 -> remains IDLE, obusy = 0; a second istart while busy is ignored and index_M_out is unchanged.
- rst asserted at k = 500 of a data symbol -> all outputs 0 immediately; the next istart begins with osop at k = 0 in PRE.
- cfg_M = 5, cfg_SS = 9 latched -> index_M_out = 5 and index_SS_out = 9 for the whole frame, even when cfg inputs change mid-frame.

Source files
------------

// File: rtl/subc_frame_ctrl.sv
// Frame sequencer feeding the subcarrier scrambler: walks every FFT bin per symbol,
// classifies it, and pulls QAM samples from the mapper FIFO only for data bins.
module subc_frame_ctrl #(
  parameter int                   fft_depth  = 12,
  parameter int                   NFFT_LOG   = 10,
  parameter int                   GUARD      = 112,
  parameter int                   PILOT_STEP = 8,
  parameter int                   N_PRE      = 1,
  parameter logic [fft_depth-1:0] PILOT_AMP  = 12'd1024,
  parameter logic [fft_depth-1:0] PRE_AMP    = 12'd1448
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 istart,
  input  logic [2:0]           cfg_M,
  input  logic [3:0]           cfg_SS,
  input  logic [7:0]           cfg_nsym,
  input  logic [fft_depth-1:0] idata_i,
  input  logic [fft_depth-1:0] idata_q,
  input  logic                 idata_val,
  output logic                 odata_rdy,
  output logic [fft_depth-1:0] osubc_i,
  output logic [fft_depth-1:0] osubc_q,
  output logic [1:0]           oindex_subc,
  output logic [2:0]           index_M_out,
  output logic [3:0]           index_SS_out,
  output logic                 osop,
  output logic                 oval,
  output logic                 oeop,
  output logic                 obusy,
  output logic                 odone
);

  localparam int N = 1 << NFFT_LOG;
  localparam logic [NFFT_LOG-1:0] K_LAST   = NFFT_LOG'(N - 1);
  localparam logic [NFFT_LOG-1:0] NULL_LO  = NFFT_LOG'(N / 2 - GUARD);
  localparam logic [NFFT_LOG-1:0] NULL_HI  = NFFT_LOG'(N / 2 + GUARD);
  localparam logic [NFFT_LOG-1:0] P_MASK   = NFFT_LOG'(PILOT_STEP - 1);
  localparam logic [7:0]          PRE_LAST = 8'((N_PRE > 0) ? N_PRE - 1 : 0);

  localparam logic [1:0] T_NULL  = 2'd0;
  localparam logic [1:0] T_DATA  = 2'd1;
  localparam logic [1:0] T_PILOT = 2'd2;
  localparam logic [1:0] T_PRE   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [NFFT_LOG-1:0]  k_q, k_d;
  logic [7:0]           sym_q, sym_d;
  logic [7:0]           nsym_q;
  logic [2:0]           m_q;
  logic [3:0]           ss_q;
  logic                 latch;

  logic                 val_q, val_d, sop_q, sop_d, eop_q, eop_d;
  logic [1:0]           type_q, type_d;
  logic [fft_depth-1:0] i_q, i_d, q_q, q_d;
  logic                 busy_q, done_q;

  logic is_null, is_pilot, is_data, k_last, advance;

  assign is_null  = (k_q == '0) || ((k_q >= NULL_LO) && (k_q < NULL_HI));
  assign is_pilot = !is_null && ((k_q & P_MASK) == '0);
  assign is_data  = !is_null && !is_pilot;
  assign k_last   = (k_q == K_LAST);

  assign odata_rdy = (state_q == S_DATA) && is_data;
  // Only data bins can stall; everything else advances every cycle.
  assign advance   = (state_q == S_PRE) ||
                     ((state_q == S_DATA) && (!is_data || idata_val));

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d = state_q;
    k_d     = k_q;
    sym_d   = sym_q;
    latch   = 1'b0;
    val_d   = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    type_d  = T_NULL;
    i_d     = '0;
    q_d     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (istart && (cfg_nsym != 8'd0)) begin
          latch   = 1'b1;
          state_d = (N_PRE == 0) ? S_DATA : S_PRE;
          k_d     = '0;
          sym_d   = '0;
        end
      end
      S_PRE, S_DATA: begin
        if (advance) begin
          k_d   = k_q + NFFT_LOG'(1);
          val_d = 1'b1;
          sop_d = (k_q == '0);
          eop_d = k_last;
          if (state_q == S_PRE) begin
            if (!is_null) begin
              type_d = T_PRE;
              i_d    = k_q[0] ? '0 : PRE_AMP;
            end
          end else if (is_pilot) begin
            type_d = T_PILOT;
            i_d    = PILOT_AMP;
          end else if (is_data) begin
            type_d = T_DATA;
            i_d    = idata_i;
            q_d    = idata_q;
          end
          if (k_last) begin
            sym_d = sym_q + 8'd1;
            if ((state_q == S_PRE) && (sym_q == PRE_LAST)) begin
              state_d = S_DATA;
              sym_d   = '0;
            end else if ((state_q == S_DATA) && (sym_q == nsym_q - 8'd1)) begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      sym_q   <= '0;
      nsym_q  <= '0;
      m_q     <= '0;
      ss_q    <= '0;
      val_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      type_q  <= T_NULL;
      i_q     <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sym_q   <= sym_d;
      val_q   <= val_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      type_q  <= type_d;
      i_q     <= i_d;
      q_q     <= q_d;
      // Busy/done are delayed one cycle to line up with the registered bin stream.
      busy_q  <= (state_q != S_IDLE);
      done_q  <= (state_q == S_DONE);
      if (latch) begin
        nsym_q <= cfg_nsym;
        m_q    <= cfg_M;
        ss_q   <= cfg_SS;
      end
    end
  end

  assign osubc_i      = i_q;
  assign osubc_q      = q_q;
  assign oindex_subc  = type_q;
  assign index_M_out  = m_q;
  assign index_SS_out = ss_q;
  assign osop         = sop_q;
  assign oval         = val_q;
  assign oeop         = eop_q;
  assign obusy        = busy_q;
  assign odone        = done_q;

endmodule

// File: tb/tb_subc_frame_ctrl.sv
// Directed bench for subc_frame_ctrl: full frames, stalls, ignored starts and mid-frame reset.
module tb_subc_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        istart;
  logic [2:0]  cfg_M;
  logic [3:0]  cfg_SS;
  logic [7:0]  cfg_nsym;
  logic [11:0] idata_i, idata_q;
  logic        idata_val;
  logic        odata_rdy;
  logic [11:0] osubc_i, osubc_q;
  logic [1:0]  oindex_subc;
  logic [2:0]  index_M_out;
  logic [3:0]  index_SS_out;
  logic        osop, oval, oeop, obusy, odone;

  subc_frame_ctrl dut (
    .clk(clk), .rst(rst), .istart(istart), .cfg_M(cfg_M), .cfg_SS(cfg_SS),
    .cfg_nsym(cfg_nsym), .idata_i(idata_i), .idata_q(idata_q), .idata_val(idata_val),
    .odata_rdy(odata_rdy), .osubc_i(osubc_i), .osubc_q(osubc_q),
    .oindex_subc(oindex_subc), .index_M_out(index_M_out), .index_SS_out(index_SS_out),
    .osop(osop), .oval(oval), .oeop(oeop), .obusy(obusy), .odone(odone)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tx, rx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bin type for the default geometry: null 0 and 400..623, pilot every 8th bin.
  function automatic int exp_type(int kk, bit pre);
    if (kk == 0 || (kk >= 400 && kk < 624)) return 0;
    if (pre) return 3;
    if (kk % 8 == 0) return 2;
    return 1;
  endfunction

  task automatic run_frame(input int nsym, input bit toggle, input bit poke);
    int total = (1 + nsym) * 1024;
    int budget = total * 3 + 20;
    int bk = 0, kk, t, ei, eq;
    int n_val = 0, n_sop = 0, n_eop = 0, n_done = 0;
    int first_val = -1, last_val = -1, eop_cyc = -1, done_cyc = -1, fall_cyc = -1;
    int bin_err = 0, zero_err = 0, gap_err = 0, rdy_err = 0, cfg_err = 0;
    bit exp_rdy;
    @(negedge clk);
    istart = 1'b1; cfg_M = 3'd5; cfg_SS = 4'd9; cfg_nsym = nsym[7:0]; idata_val = 1'b0;
    tx = 0; rx = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      istart = 1'b0;
      if (cyc == 1) check("busy_rise", obusy, 1);
      if (index_M_out !== 3'd5 || index_SS_out !== 4'd9) cfg_err++;
      if (oval) begin
        kk = bk % 1024;
        t  = exp_type(kk, bk < 1024);
        ei = (t == 3) ? ((kk % 2 == 0) ? 1448 : 0) : (t == 2) ? 1024 : (t == 1) ? (rx & 12'hfff) : 0;
        eq = (t == 1) ? (~rx & 12'hfff) : 0;
        if (oindex_subc !== t[1:0] || osubc_i !== ei[11:0] || osubc_q !== eq[11:0] ||
            osop !== (kk == 0) || oeop !== (kk == 1023)) bin_err++;
        if (t == 1) rx++;
        if (bk == 0) check("pre_k0_type", oindex_subc, 0);
        if (bk == 2) check("pre_k2_I", osubc_i, 1448);
        if (bk == 3) check("pre_k3_I", osubc_i, 0);
        if (bk == 1024 + 8) check("pilot_k8_I", osubc_i, 1024);
        if (first_val < 0) first_val = cyc;
        last_val = cyc;
        n_val++;
        n_sop += int'(osop);
        n_eop += int'(oeop);
        if (oeop) eop_cyc = cyc;
        bk++;
      end else begin
        if (osubc_i !== 12'd0 || osubc_q !== 12'd0 || osop || oeop) zero_err++;
        if (first_val >= 0 && bk < total && !(bk >= 1024 && exp_type(bk % 1024, 1'b0) == 1))
          gap_err++;
      end
      if (odone) begin n_done++; done_cyc = cyc; end
      if (cyc >= 1 && !obusy) begin fall_cyc = cyc; break; end
      exp_rdy = (bk < total) && (bk >= 1024) && (exp_type(bk % 1024, 1'b0) == 1);
      if (odata_rdy !== exp_rdy) rdy_err++;
      idata_val = toggle ? (cyc % 2 == 0) : 1'b1;
      idata_i   = tx[11:0];
      idata_q   = ~tx[11:0];
      if (cyc == 100) begin cfg_M = 3'd3; cfg_SS = 4'd4; end
      if (poke && cyc == 1500) begin istart = 1'b1; cfg_M = 3'd2; cfg_nsym = 8'd1; end
      if (idata_val && odata_rdy) tx++;
    end
    check("timeout", fall_cyc >= 0, 1);
    check("n_val", n_val, total);
    check("n_sop", n_sop, 1 + nsym);
    check("n_eop", n_eop, 1 + nsym);
    check("n_transfer", tx, 700 * nsym);
    check("n_done", n_done, 1);
    check("done_after_eop", done_cyc - eop_cyc, 1);
    check("busy_fall", fall_cyc - done_cyc, 1);
    check("bin_err", bin_err, 0);
    check("zero_err", zero_err, 0);
    check("gap_err", gap_err, 0);
    check("rdy_err", rdy_err, 0);
    check("cfg_err", cfg_err, 0);
    if (!toggle) check("span", last_val - first_val, total - 1);
  endtask

  initial begin
    int bk;
    rst = 1'b1; istart = 1'b0; cfg_M = '0; cfg_SS = '0; cfg_nsym = '0;
    idata_i = '0; idata_q = '0; idata_val = 1'b0;
    #1;
    check("rst_oval", oval, 0);
    check("rst_rdy", odata_rdy, 0);
    check("rst_busy", obusy, 0);
    check("rst_M", index_M_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_frame(2, 1'b0, 1'b1);

    @(negedge clk);
    istart = 1'b1; cfg_M = 3'd7; cfg_nsym = 8'd0;
    @(negedge clk);
    istart = 1'b0;
    repeat (3) @(negedge clk);
    check("nsym0_busy", obusy, 0);
    check("nsym0_oval", oval, 0);
    check("nsym0_M", index_M_out, 5);

    run_frame(1, 1'b1, 1'b0);

    @(negedge clk);
    istart = 1'b1; cfg_M = 3'd5; cfg_SS = 4'd9; cfg_nsym = 8'd1; idata_val = 1'b1;
    bk = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      istart = 1'b0;
      if (oval) bk++;
      if (bk == 1524) break;
    end
    check("rst_reach", bk, 1524);
    rst = 1'b1;
    #1;
    check("mid_rst_oval", oval, 0);
    check("mid_rst_i", osubc_i, 0);
    check("mid_rst_type", oindex_subc, 0);
    check("mid_rst_busy", obusy, 0);
    check("mid_rst_rdy", odata_rdy, 0);
    check("mid_rst_M", index_M_out, 0);
    @(negedge clk);
    rst = 1'b0;

    run_frame(1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
